controlador_quantum: RTL and testbench
======================================

Name: controlador_quantum

Overview:
- Preemption and context-save stage directly upstream of the CPU PC-update logic.
- Counts the quantum of the running user process and detects three events: quantum expiry, IO instruction, process end.
- On an event it saves the interrupted PC into a per-process table and issues one-cycle `troca_contexto` / `desvio_io` pulses that steer the PC to the scheduler or IO routine.
- Also tracks which processes are ready and offers the next ready process in round-robin order to the scheduler.

Parameters:
- QUANTUM, 16: instructions (enabled clocks) per time slice; legal range ≥2.
- NUM_PROC, 8: process table entries.
- PROC_W, 3: process id width; must satisfy 2**PROC_W ≥ NUM_PROC.
- QW, 5: quantum counter width; must satisfy 2**QW > QUANTUM.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- habilita  in  1  count enable; 0 during BIOS, scheduler, IO routine or CPU halt.
- pc  in  32  PC of the instruction currently executing.
- processo_atual  in  PROC_W  id of the running process.
- inicia_processo  in  1  scheduler dispatched `processo_atual`; starts a new slice.
- instrucao_io  in  1  current instruction is IO (decoded by the control unit).
- fim_processo  in  1  current instruction ends the process.
- cria_processo  in  1  mark `cria_id` ready and clear its saved PC.
- cria_id  in  PROC_W  id being created.
- troca_contexto  out  1  one-cycle pulse: jump to scheduler.
- desvio_io  out  1  one-cycle pulse: jump to IO routine.
- pc_processo_trocado  out  32  saved PC of the last interrupted process.
- pc_salvo_proximo  out  32  table entry of `proximo_processo` (combinational read).
- proximo_processo  out  PROC_W  next ready id, round-robin.
- ha_pronto  out  1  at least one process is ready.
- contagem  out  QW  current quantum count.

Behaviour:
Reset:
- Applied only at a posedge with `reset`=1.
- State goes to OCIOSO; `contagem`=0, pulses=0, `pc_processo_trocado`=0.
- Every ready bit is cleared and every table entry is set to 0.
- Reset has priority over all other inputs, including mid-slice.

State machine (OCIOSO, EXECUTANDO, TROCA, IO, ESPERA):
- OCIOSO:
  - `inicia_processo`=1 → EXECUTANDO, `contagem`=0.
  - All other inputs ignored, except `cria_processo`.
- EXECUTANDO: each clock with `habilita`=1, events are checked in priority order:
  1. `fim_processo`=1: clear ready[`processo_atual`], entry←0, `pc_processo_trocado`←`pc` → TROCA.
  2. `instrucao_io`=1: entry[`processo_atual`]←`pc`+1, `pc_processo_trocado`←`pc`+1 → IO.
  3. `contagem`==QUANTUM-1: entry←`pc`+1, `pc_processo_trocado`←`pc`+1 → TROCA.
  4. Otherwise `contagem`++.
- EXECUTANDO with `habilita`=0: hold everything; no event is detected.
- TROCA: `troca_contexto`=1 for exactly this cycle, `contagem`=0 → ESPERA.
- IO: `desvio_io`=1 for exactly this cycle, `contagem`=0 → ESPERA.
- ESPERA: `inicia_processo`=1 → EXECUTANDO with `contagem`=0.
- `inicia_processo` in EXECUTANDO restarts the slice (`contagem`=0), unless an event fires in the same cycle; the event wins.
- Both pulses are registered outputs (state decode), never combinational from the inputs. Latency is one clock from the event-sampling edge to the pulse.

Round-robin:
- `proximo_processo` = lowest ready id strictly greater than `processo_atual`, wrapping to 0.
- If only `processo_atual` is ready, it is selected.
- If none are ready: `ha_pronto`=0 and `proximo_processo`=0.
- Purely combinational from the ready bits and `processo_atual`.

Table and arithmetic:
- `cria_processo` is honoured in every state.
- If it coincides with `fim_processo` for the same id, `cria_processo` wins (ready=1, entry=0).
- `cria_id` ≥ NUM_PROC is ignored.
- `pc`+1 wraps modulo 2**32.

Test Plan:
- Reset, create id 2, `inicia_processo` with id 2, `habilita`=1, `pc`=100..115 → `troca_contexto` pulses one cycle after `pc`=115 is sampled; `pc_processo_trocado`=116; entry[2]=116; `contagem`=0.
- `habilita` toggles 1/0 every cycle → the pulse arrives after exactly 16 enabled cycles (31 clocks); `contagem` holds while disabled.
- `instrucao_io` at `pc`=40 with `contagem`=15 → `desvio_io`=1 one cycle, `troca_contexto` stays 0, saved PC 41.
- `fim_processo` and `instrucao_io` together for id 3 → `troca_contexto` pulse, ready[3]=0, entry[3]=0, no `desvio_io`.
- Ready {1,4,6}, `processo_atual`=6 → `proximo_processo`=1. Ready {6} → 6. Ready {} → `ha_pronto`=0, `proximo_processo`=0.
- Reset asserted at `contagem`=9 → next cycle OCIOSO, all outputs 0, ready bits clear; a later `inicia_processo` restarts from 0.

Source files
------------

// File: rtl/controlador_quantum.sv
// Preemption and context-save stage ahead of the PC-update logic: counts the quantum of the
// running process, saves its PC on quantum expiry / IO / process end, and offers the next process.
module controlador_quantum #(
    parameter int unsigned QUANTUM  = 16,
    parameter int unsigned NUM_PROC = 8,
    parameter int unsigned PROC_W   = 3,
    parameter int unsigned QW       = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              habilita,
    input  logic [31:0]       pc,
    input  logic [PROC_W-1:0] processo_atual,
    input  logic              inicia_processo,
    input  logic              instrucao_io,
    input  logic              fim_processo,
    input  logic              cria_processo,
    input  logic [PROC_W-1:0] cria_id,
    output logic              troca_contexto,
    output logic              desvio_io,
    output logic [31:0]       pc_processo_trocado,
    output logic [31:0]       pc_salvo_proximo,
    output logic [PROC_W-1:0] proximo_processo,
    output logic              ha_pronto,
    output logic [QW-1:0]     contagem
);

    localparam int unsigned IdW = PROC_W + 1;
    localparam logic [IdW-1:0] NumProcId = IdW'(NUM_PROC);
    localparam logic [QW-1:0] UltimaContagem = QW'(QUANTUM - 1);

    typedef enum logic [2:0] {
        StOcioso,
        StExecutando,
        StTroca,
        StIo,
        StEspera
    } estado_e;

    estado_e             estado_q, estado_d;
    logic [QW-1:0]       contagem_q, contagem_d;
    logic [31:0]         pc_trocado_q, pc_trocado_d;
    logic [NUM_PROC-1:0] pronto_q, pronto_d;
    logic [31:0]         tabela_q [NUM_PROC];
    logic [31:0]         tabela_d [NUM_PROC];

    logic [31:0]       pc_mais_um;
    logic              atual_valido;
    logic              cria_valido;
    logic [PROC_W-1:0] proximo;
    logic              achou;

    assign pc_mais_um   = pc + 32'd1;
    assign atual_valido = {1'b0, processo_atual} < NumProcId;
    assign cria_valido  = {1'b0, cria_id} < NumProcId;

    always_comb begin
        estado_d     = estado_q;
        contagem_d   = contagem_q;
        pc_trocado_d = pc_trocado_q;
        pronto_d     = pronto_q;
        tabela_d     = tabela_q;

        unique case (estado_q)
            StOcioso, StEspera: begin
                if (inicia_processo) begin
                    estado_d   = StExecutando;
                    contagem_d = '0;
                end
            end
            StExecutando: begin
                if (habilita && fim_processo) begin
                    if (atual_valido) begin
                        pronto_d[processo_atual] = 1'b0;
                        tabela_d[processo_atual] = '0;
                    end
                    pc_trocado_d = pc;
                    contagem_d   = '0;
                    estado_d     = StTroca;
                end else if (habilita && instrucao_io) begin
                    if (atual_valido) begin
                        tabela_d[processo_atual] = pc_mais_um;
                    end
                    pc_trocado_d = pc_mais_um;
                    contagem_d   = '0;
                    estado_d     = StIo;
                end else if (habilita && (contagem_q == UltimaContagem)) begin
                    if (atual_valido) begin
                        tabela_d[processo_atual] = pc_mais_um;
                    end
                    pc_trocado_d = pc_mais_um;
                    contagem_d   = '0;
                    estado_d     = StTroca;
                end else if (inicia_processo) begin
                    contagem_d = '0;
                end else if (habilita) begin
                    contagem_d = contagem_q + QW'(1);
                end
            end
            StTroca, StIo: begin
                contagem_d = '0;
                estado_d   = StEspera;
            end
            default: begin
                contagem_d = '0;
                estado_d   = StOcioso;
            end
        endcase

        // Creation is applied last so it overrides a same-cycle process end on the same id.
        if (cria_processo && cria_valido) begin
            pronto_d[cria_id] = 1'b1;
            tabela_d[cria_id] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= StOcioso;
            contagem_q   <= '0;
            pc_trocado_q <= '0;
            pronto_q     <= '0;
            for (int unsigned i = 0; i < NUM_PROC; i++) begin
                tabela_q[i] <= '0;
            end
        end else begin
            estado_q     <= estado_d;
            contagem_q   <= contagem_d;
            pc_trocado_q <= pc_trocado_d;
            pronto_q     <= pronto_d;
            tabela_q     <= tabela_d;
        end
    end

    // First pass looks above the current id; the second wraps around from 0 and may hit it.
    always_comb begin
        proximo = '0;
        achou   = 1'b0;
        for (int unsigned i = 0; i < NUM_PROC; i++) begin
            if (!achou && pronto_q[i] && (PROC_W'(i) > processo_atual)) begin
                proximo = PROC_W'(i);
                achou   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_PROC; i++) begin
            if (!achou && pronto_q[i]) begin
                proximo = PROC_W'(i);
                achou   = 1'b1;
            end
        end
    end

    assign troca_contexto      = (estado_q == StTroca);
    assign desvio_io           = (estado_q == StIo);
    assign pc_processo_trocado = pc_trocado_q;
    assign contagem            = contagem_q;
    assign ha_pronto           = |pronto_q;
    assign proximo_processo    = proximo;
    assign pc_salvo_proximo    = tabela_q[proximo];

endmodule

// File: tb/tb_controlador_quantum.sv
// Directed and randomized checks of controlador_quantum against a slice-level behavioural model.
module tb_controlador_quantum;

    localparam int QUANTUM = 16;
    localparam int NUM     = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        habilita;
    logic [31:0] pc;
    logic [2:0]  processo_atual;
    logic        inicia_processo;
    logic        instrucao_io;
    logic        fim_processo;
    logic        cria_processo;
    logic [2:0]  cria_id;
    logic        troca_contexto;
    logic        desvio_io;
    logic [31:0] pc_processo_trocado;
    logic [31:0] pc_salvo_proximo;
    logic [2:0]  proximo_processo;
    logic        ha_pronto;
    logic [4:0]  contagem;

    controlador_quantum #(
        .QUANTUM (QUANTUM),
        .NUM_PROC(NUM),
        .PROC_W  (3),
        .QW      (5)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .habilita           (habilita),
        .pc                 (pc),
        .processo_atual     (processo_atual),
        .inicia_processo    (inicia_processo),
        .instrucao_io       (instrucao_io),
        .fim_processo       (fim_processo),
        .cria_processo      (cria_processo),
        .cria_id            (cria_id),
        .troca_contexto     (troca_contexto),
        .desvio_io          (desvio_io),
        .pc_processo_trocado(pc_processo_trocado),
        .pc_salvo_proximo   (pc_salvo_proximo),
        .proximo_processo   (proximo_processo),
        .ha_pronto          (ha_pronto),
        .contagem           (contagem)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: a slice is either running or not; a pending pulse occupies the cycle after an event.
    bit          m_run;
    int          m_cnt;
    bit          m_troca;
    bit          m_io;
    logic [31:0] m_saved;
    bit [NUM-1:0] m_ready;
    logic [31:0] m_tab [NUM];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit nt = 0;
        bit ni = 0;
        int a = int'(processo_atual);
        if (reset) begin
            m_run = 0; m_cnt = 0; m_saved = '0; m_ready = '0; m_troca = 0; m_io = 0;
            for (int i = 0; i < NUM; i++) m_tab[i] = '0;
            return;
        end
        if (m_troca || m_io) begin
            m_run = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (inicia_processo) begin m_run = 1; m_cnt = 0; end
        end else if (habilita && fim_processo) begin
            m_ready[a] = 0; m_tab[a] = '0; m_saved = pc; nt = 1; m_run = 0; m_cnt = 0;
        end else if (habilita && instrucao_io) begin
            m_tab[a] = pc + 32'd1; m_saved = pc + 32'd1; ni = 1; m_run = 0; m_cnt = 0;
        end else if (habilita && m_cnt == QUANTUM - 1) begin
            m_tab[a] = pc + 32'd1; m_saved = pc + 32'd1; nt = 1; m_run = 0; m_cnt = 0;
        end else if (inicia_processo) begin
            m_cnt = 0;
        end else if (habilita) begin
            m_cnt++;
        end
        if (cria_processo && int'(cria_id) < NUM) begin
            m_ready[cria_id] = 1; m_tab[cria_id] = '0;
        end
        m_troca = nt;
        m_io    = ni;
    endtask

    task automatic check_all();
        int exp_prox = 0;
        for (int k = 1; k <= NUM; k++) begin
            int idx = (int'(processo_atual) + k) % NUM;
            if (m_ready[idx]) begin exp_prox = idx; break; end
        end
        chk("troca_contexto", 32'(troca_contexto), 32'(m_troca));
        chk("desvio_io", 32'(desvio_io), 32'(m_io));
        chk("contagem", 32'(contagem), 32'(m_cnt));
        chk("pc_processo_trocado", pc_processo_trocado, m_saved);
        chk("ha_pronto", 32'(ha_pronto), 32'(|m_ready));
        chk("proximo_processo", 32'(proximo_processo), 32'(exp_prox));
        chk("pc_salvo_proximo", pc_salvo_proximo, m_tab[exp_prox]);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic criar(input logic [2:0] id);
        cria_processo = 1; cria_id = id; step(); cria_processo = 0;
    endtask

    initial begin
        int n_pulse;
        reset = 1; habilita = 0; pc = '0; processo_atual = '0; inicia_processo = 0;
        instrucao_io = 0; fim_processo = 0; cria_processo = 0; cria_id = '0;
        m_run = 0; m_cnt = 0; m_troca = 0; m_io = 0; m_saved = '0; m_ready = '0;
        for (int i = 0; i < NUM; i++) m_tab[i] = '0;

        step();
        chk("reset_contagem", 32'(contagem), 32'd0);
        chk("reset_troca", 32'(troca_contexto), 32'd0);
        reset = 0;

        // Full quantum on process 2
        criar(3'd2);
        processo_atual = 3'd2; inicia_processo = 1; step(); inicia_processo = 0;
        habilita = 1;
        for (int k = 0; k < 16; k++) begin pc = 32'(100 + k); step(); end
        habilita = 0;
        chk("quantum_pulse", 32'(troca_contexto), 32'd1);
        chk("quantum_pc", pc_processo_trocado, 32'd116);
        chk("quantum_entry", pc_salvo_proximo, 32'd116);
        chk("quantum_cnt", 32'(contagem), 32'd0);
        step();
        chk("quantum_pulse_end", 32'(troca_contexto), 32'd0);

        // habilita toggling: 16 enabled cycles in 31 clocks
        inicia_processo = 1; step(); inicia_processo = 0;
        n_pulse = 0;
        for (int k = 0; k < 31; k++) begin
            habilita = (k % 2 == 0); pc = 32'(200 + k); step();
            if (k < 30) n_pulse += int'(troca_contexto);
        end
        habilita = 0;
        chk("toggle_early_pulse", 32'(n_pulse), 32'd0);
        chk("toggle_pulse", 32'(troca_contexto), 32'd1);
        step();

        // IO wins over quantum expiry
        inicia_processo = 1; step(); inicia_processo = 0;
        habilita = 1;
        for (int k = 0; k < 15; k++) begin pc = 32'(300 + k); step(); end
        chk("io_cnt15", 32'(contagem), 32'd15);
        pc = 32'd40; instrucao_io = 1; step(); instrucao_io = 0; habilita = 0;
        chk("io_pulse", 32'(desvio_io), 32'd1);
        chk("io_no_troca", 32'(troca_contexto), 32'd0);
        chk("io_pc", pc_processo_trocado, 32'd41);
        step();
        chk("io_pulse_end", 32'(desvio_io), 32'd0);

        // Process end beats IO for id 3
        criar(3'd3);
        processo_atual = 3'd3; inicia_processo = 1; step(); inicia_processo = 0;
        habilita = 1; fim_processo = 1; instrucao_io = 1; pc = 32'd500; step();
        fim_processo = 0; instrucao_io = 0; habilita = 0;
        chk("fim_troca", 32'(troca_contexto), 32'd1);
        chk("fim_no_io", 32'(desvio_io), 32'd0);
        chk("fim_pc", pc_processo_trocado, 32'd500);
        chk("fim_next", 32'(proximo_processo), 32'd2);
        step();

        // Round-robin selection
        reset = 1; step(); reset = 0;
        processo_atual = 3'd6;
        criar(3'd1); criar(3'd4); criar(3'd6);
        chk("rr_wrap", 32'(proximo_processo), 32'd1);
        reset = 1; step(); reset = 0;
        criar(3'd6);
        chk("rr_self", 32'(proximo_processo), 32'd6);
        reset = 1; step(); reset = 0;
        chk("rr_none_hp", 32'(ha_pronto), 32'd0);
        chk("rr_none_id", 32'(proximo_processo), 32'd0);

        // Reset mid-slice
        criar(3'd5);
        processo_atual = 3'd5; inicia_processo = 1; step(); inicia_processo = 0;
        habilita = 1;
        for (int k = 0; k < 9; k++) begin pc = 32'(700 + k); step(); end
        chk("mid_cnt9", 32'(contagem), 32'd9);
        reset = 1; step(); reset = 0;
        chk("mid_reset_cnt", 32'(contagem), 32'd0);
        chk("mid_reset_ready", 32'(ha_pronto), 32'd0);
        step();
        chk("mid_idle_cnt", 32'(contagem), 32'd0);
        inicia_processo = 1; step(); inicia_processo = 0;
        step();
        chk("mid_restart_cnt", 32'(contagem), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(63) == 0);
            habilita        = ($urandom_range(3) != 0);
            pc              = $urandom;
            processo_atual  = 3'($urandom_range(7));
            inicia_processo = ($urandom_range(7) == 0);
            instrucao_io    = ($urandom_range(15) == 0);
            fim_processo    = ($urandom_range(31) == 0);
            cria_processo   = ($urandom_range(3) == 0);
            cria_id         = 3'($urandom_range(7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
